pc_fetch_ctrl: RTL and testbench

Sequential fetch controller that owns the architectural PC register, drives instruction-memory requests, and hands fetched words to decode through a one-entry skid buffer. It sits between the combinational next-PC unit and instruction memory. It takes sequential PC+4 internally, accepts taken-branch/jump redirects from the next-PC unit, and squashes in-flight or buffered wrong-path fetches.

---
 rtl/pc_fetch_ctrl_if.sv | 25 ++
 rtl/pc_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and imem.
// One request in flight at a time: req/gnt handshake, then a single rvalid beat.
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues one imem request at a time, and
// holds the returned word in a one-entry buffer until decode takes it.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pc_fetch_ctrl_if.master         imem,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [31:0]             instr_pc,
    input  logic                    instr_ready,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    fetch_adel
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic        squash, squash_nxt;
    logic        buf_valid, buf_valid_nxt;
    logic        buf_load;
    logic [31:0] buf_instr, buf_pc;
    logic        adel_nxt;

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        req_pc_nxt    = req_pc;
        squash_nxt    = squash;
        buf_valid_nxt = buf_valid;
        buf_load      = 1'b0;
        adel_nxt      = fetch_adel | (redirect_valid & (|redirect_pc[1:0]));

        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
                if (imem.imem_gnt) begin
                    state_nxt    = ST_WAIT;
                    req_pc_nxt   = fetch_pc;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    // A grant that coincides with a redirect fetched the wrong path.
                    squash_nxt   = redirect_valid;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    squash_nxt = 1'b0;
                    if (squash || redirect_valid) begin
                        state_nxt = ST_REQ;
                    end else begin
                        buf_load      = 1'b1;
                        buf_valid_nxt = 1'b1;
                        state_nxt     = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    squash_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (instr_ready || redirect_valid) begin
                    buf_valid_nxt = 1'b0;
                    state_nxt     = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Redirect overrides the sequential PC update in every state.
        if (redirect_valid) begin
            fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fetch_pc   <= RESET_PC;
            req_pc     <= RESET_PC;
            squash     <= 1'b0;
            buf_valid  <= 1'b0;
            buf_instr  <= 32'h0;
            buf_pc     <= 32'h0;
            fetch_adel <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            req_pc     <= req_pc_nxt;
            squash     <= squash_nxt;
            buf_valid  <= buf_valid_nxt;
            fetch_adel <= adel_nxt;
            if (buf_load) begin
                buf_instr <= imem.imem_rdata;
                buf_pc    <= req_pc;
            end
        end
    end

    assign imem.imem_req  = (state == ST_REQ);
    assign imem.imem_addr = fetch_pc;
    assign instr_valid    = buf_valid;
    assign instr          = buf_instr;
    assign instr_pc       = buf_pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: transaction-level fetch model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_adel;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_adel     (fetch_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Stimulus knobs
    bit          gnt_en, ready_en, rd_en;
    logic [31:0] rd_pc;
    int          mem_lat;

    // Instruction memory responder
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;

    // Transaction-level model of the fetch stream
    bit          m_started, m_out, m_out_wrong, m_buf, m_adel;
    logic [31:0] m_pc, m_out_addr, m_buf_addr, m_buf_data;

    logic [31:0] deliv_pc[$];
    int          deliv_cyc[$];
    logic [31:0] grant_q[$];

    logic [31:0] old_pc;
    int          g_idx;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA55A, a[31:16] ^ 16'h0F0F};
    endfunction

    function automatic bit m_req();
        return m_started && !m_out && !m_buf;
    endfunction

    function automatic bit in_deliv(input logic [31:0] a);
        foreach (deliv_pc[i]) if (deliv_pc[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    task automatic reset_model();
        m_started   = 1'b0;
        m_out       = 1'b0;
        m_out_wrong = 1'b0;
        m_buf       = 1'b0;
        m_adel      = 1'b0;
        m_pc        = RESET_PC;
        m_out_addr  = 32'h0;
        m_buf_addr  = 32'h0;
        m_buf_data  = 32'h0;
    endtask

    task automatic compare();
        check("imem_req", {31'h0, bus.imem_req}, {31'h0, m_req()});
        check("imem_addr", bus.imem_addr, m_pc);
        check("instr_valid", {31'h0, instr_valid}, {31'h0, m_buf});
        check("fetch_adel", {31'h0, fetch_adel}, {31'h0, m_adel});
        if (m_buf) begin
            check("instr_pc", instr_pc, m_buf_addr);
            check("instr", instr, m_buf_data);
        end
    endtask

    task automatic drive();
        bus.imem_gnt    = gnt_en;
        bus.imem_rvalid = mem_pend && (mem_cnt == 0);
        bus.imem_rdata  = bus.imem_rvalid ? mem_word(mem_addr) : 32'h0;
        instr_ready     = ready_en;
        redirect_valid  = rd_en;
        redirect_pc     = rd_pc;
        if (bus.imem_rvalid) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt != 0) mem_cnt--;
        if (bus.imem_req && bus.imem_gnt) begin
            mem_pend = 1'b1;
            mem_addr = bus.imem_addr;
            mem_cnt  = mem_lat - 1;
        end
    endtask

    task automatic update();
        bit grant, rv, rd, hs;
        grant = m_req() && bus.imem_gnt;
        rv    = bus.imem_rvalid;
        rd    = redirect_valid;
        hs    = m_buf && instr_ready;
        if (hs) begin
            deliv_pc.push_back(m_buf_addr);
            deliv_cyc.push_back(cyc);
        end
        if (m_buf && (hs || rd)) m_buf = 1'b0;
        if (m_out && rv) begin
            if (!m_out_wrong && !rd) begin
                m_buf      = 1'b1;
                m_buf_addr = m_out_addr;
                m_buf_data = mem_word(m_out_addr);
            end
            m_out = 1'b0;
        end else if (m_out && rd) begin
            m_out_wrong = 1'b1;
        end
        if (grant) begin
            m_out       = 1'b1;
            m_out_addr  = m_pc;
            m_out_wrong = rd;
            grant_q.push_back(m_pc);
        end
        if (rd) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) m_adel = 1'b1;
        end else if (grant) begin
            m_pc = m_pc + 32'd4;
        end
        m_started = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        compare();
        drive();
        update();
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!m_req() && k < 50) begin cycle(); k++; end
        if (!m_req()) timeout(name);
    endtask

    task automatic wait_buf(input string name);
        int k = 0;
        while (!m_buf && k < 50) begin cycle(); k++; end
        if (!m_buf) timeout(name);
    endtask

    task automatic wait_deliv(input int n, input string name);
        int k = 0;
        while (deliv_pc.size() < n && k < 60) begin cycle(); k++; end
        if (deliv_pc.size() < n) timeout(name);
    endtask

    initial begin
        rst_n = 1'b0;
        gnt_en = 1'b1; ready_en = 1'b1; rd_en = 1'b0; rd_pc = 32'h0; mem_lat = 1;
        mem_pend = 1'b0; mem_addr = 32'h0; mem_cnt = 0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        reset_model();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h0000_3000);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_adel", {31'h0, fetch_adel}, 32'h0);
        rst_n = 1'b1;
        drive();
        update();

        // Free run: three fetches, one every 3 cycles
        wait_deliv(3, "freerun");
        if (deliv_pc.size() >= 3 && grant_q.size() >= 3) begin
            check("fr_grant0", grant_q[0], 32'h0000_3000);
            check("fr_grant1", grant_q[1], 32'h0000_3004);
            check("fr_grant2", grant_q[2], 32'h0000_3008);
            check("fr_pc0", deliv_pc[0], 32'h0000_3000);
            check("fr_pc1", deliv_pc[1], 32'h0000_3004);
            check("fr_pc2", deliv_pc[2], 32'h0000_3008);
            check("fr_rate01", deliv_cyc[1] - deliv_cyc[0], 32'd3);
            check("fr_rate12", deliv_cyc[2] - deliv_cyc[1], 32'd3);
        end

        // Backpressure on 0x300C for 5 cycles
        ready_en = 1'b0;
        wait_buf("bp_fill");
        repeat (5) begin
            cycle();
            check("bp_valid", {31'h0, instr_valid}, 32'h1);
            check("bp_pc", instr_pc, 32'h0000_300C);
            check("bp_instr", instr, mem_word(32'h0000_300C));
            check("bp_req", {31'h0, bus.imem_req}, 32'h0);
        end
        ready_en = 1'b1;
        mem_lat  = 3;
        cycle();
        cycle();
        check("bp_next_req", {31'h0, bus.imem_req}, 32'h1);
        check("bp_next_addr", bus.imem_addr, 32'h0000_3010);

        // Redirect while waiting on 0x3010 (response comes later, squashed)
        rd_en = 1'b1; rd_pc = 32'h0000_3100;
        cycle();
        rd_en = 1'b0;
        mem_lat = 1;
        cycle();
        check("rw_addr", bus.imem_addr, 32'h0000_3100);
        check("rw_req", {31'h0, bus.imem_req}, 32'h0);
        wait_deliv(5, "rw_deliv");
        if (deliv_pc.size() >= 5) check("rw_pc", deliv_pc[4], 32'h0000_3100);
        check("rw_squashed", {31'h0, in_deliv(32'h0000_3010)}, 32'h0);

        // Redirect in the same cycle as the 0x3104 response
        wait_req("rv_req");
        cycle();
        rd_en = 1'b1; rd_pc = 32'h0000_3200;
        cycle();
        rd_en = 1'b0;
        cycle();
        check("rv_req", {31'h0, bus.imem_req}, 32'h1);
        check("rv_addr", bus.imem_addr, 32'h0000_3200);
        wait_deliv(6, "rv_deliv");
        if (deliv_pc.size() >= 6) check("rv_pc", deliv_pc[5], 32'h0000_3200);
        check("rv_dropped", {31'h0, in_deliv(32'h0000_3104)}, 32'h0);

        // Redirect with simultaneous grant in REQ
        wait_req("rg_req");
        old_pc = m_pc;
        rd_en = 1'b1; rd_pc = 32'h0000_4000;
        cycle();
        rd_en = 1'b0;
        cycle();
        check("rg_addr", bus.imem_addr, 32'h0000_4000);
        check("rg_req", {31'h0, bus.imem_req}, 32'h0);
        wait_deliv(7, "rg_deliv");
        if (deliv_pc.size() >= 7) check("rg_pc", deliv_pc[6], 32'h0000_4000);
        check("rg_squashed", {31'h0, in_deliv(old_pc)}, 32'h0);

        // Misaligned redirect in HOLD with ready, then wrap past 0xFFFF_FFFC
        wait_buf("ma_fill");
        rd_en = 1'b1; rd_pc = 32'hFFFF_FFFE;
        cycle();
        rd_en = 1'b0;
        if (deliv_pc.size() >= 8) check("ma_consumed", deliv_pc[7], 32'h0000_4004);
        else timeout("ma_consumed");
        cycle();
        check("ma_adel", {31'h0, fetch_adel}, 32'h1);
        check("ma_addr", bus.imem_addr, 32'hFFFF_FFFC);
        check("ma_req", {31'h0, bus.imem_req}, 32'h1);
        cycle();
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);
        wait_deliv(10, "wrap_deliv");
        if (deliv_pc.size() >= 10) begin
            check("wrap_pc0", deliv_pc[8], 32'hFFFF_FFFC);
            check("wrap_pc1", deliv_pc[9], 32'h0000_0000);
        end

        // Async reset pulse while waiting; the late response must be ignored
        mem_lat = 2;
        wait_req("ar_req");
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("ar_req", {31'h0, bus.imem_req}, 32'h0);
        check("ar_addr", bus.imem_addr, 32'h0000_3000);
        check("ar_valid", {31'h0, instr_valid}, 32'h0);
        check("ar_instr", instr, 32'h0);
        check("ar_instr_pc", instr_pc, 32'h0);
        check("ar_adel", {31'h0, fetch_adel}, 32'h0);
        #1 rst_n = 1'b1;
        reset_model();
        update();
        g_idx = grant_q.size();
        wait_deliv(11, "ar_deliv");
        if (grant_q.size() > g_idx) check("ar_grant", grant_q[g_idx], 32'h0000_3000);
        if (deliv_pc.size() >= 11) check("ar_pc", deliv_pc[10], 32'h0000_3000);
        check("ar_instr_word", instr, mem_word(32'h0000_3000));
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
